// File: rtl/powlib_sfifo_core_pkg.sv
// powlib_sfifo_core_pkg: shared sizing and pointer-encoding helpers for the FIFO family.
package powlib_sfifo_core_pkg;
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) r = ((1 << i) < v) ? i + 1 : r;
    return r;
  endfunction
  function automatic logic [31:0] gray_enc(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/powlib_sfifo_core_if.sv
// powlib_sfifo_core_if: write and read valid/ready streams of the FIFO.
interface powlib_sfifo_core_if #(parameter int W = 16);
  logic [W-1:0] wrdata;
  logic         wrvld;
  logic         wrrdy;
  logic [W-1:0] rddata;
  logic         rdvld;
  logic         rdrdy;
  modport slave (input wrdata, wrvld, rdrdy, output wrrdy, rddata, rdvld);
  modport master (output wrdata, wrvld, rdrdy, input wrrdy, rddata, rdvld);
endinterface

// File: rtl/powlib_dpram.sv
// powlib_dpram: dual-port RAM with synchronous write and combinational read.
module powlib_dpram
  import powlib_sfifo_core_pkg::*;
#(
  parameter int W    = 16,
  parameter int D    = 8,
  parameter int EDBG = 0,
  parameter     ID   = "DPRAM"
) (
  input  logic                clk,
  input  logic [clog2(D)-1:0] wridx,
  input  logic [W-1:0]        wrdata,
  input  logic                wrvld,
  input  logic [clog2(D)-1:0] rdidx,
  output logic [W-1:0]        rddata
);
  logic [W-1:0] mem [D];
  always_ff @(posedge clk)
    if (wrvld) mem[wridx] <= wrdata;
  assign rddata = mem[rdidx];
  // Debug tracing hook; carries no hardware.
  if (EDBG != 0 && $bits(ID) != 0) begin : g_dbg
  end
endmodule

// File: rtl/powlib_sfifo_core.sv
// powlib_sfifo_core: single-clock FWFT FIFO, capacity D-1, full detected via rdptr-1 register.
module powlib_sfifo_core
  import powlib_sfifo_core_pkg::*;
#(
  parameter int W    = 16,
  parameter int D    = 8,
  parameter int EDBG = 0,
  parameter     ID   = "SFIFO"
) (
  input logic                  clk,
  input logic                  rst,
  powlib_sfifo_core_if.slave   f
);
  localparam int WP = clog2(D);
  localparam logic [WP-1:0] LAST = WP'(D - 1);
  logic [WP-1:0] wrptr_q, wrptr_d, rdptr_q, rdptr_d, rdptrm1_q, rdptrm1_d;
  logic          wrinc, rdinc;
  assign f.wrrdy = wrptr_q != rdptrm1_q;
  assign f.rdvld = rdptr_q != wrptr_q;
  assign wrinc   = f.wrvld & f.wrrdy;
  assign rdinc   = f.rdvld & f.rdrdy;
  always_comb begin
    wrptr_d   = !wrinc ? wrptr_q : (wrptr_q == LAST) ? '0 : wrptr_q + 1'b1;
    rdptr_d   = !rdinc ? rdptr_q : (rdptr_q == LAST) ? '0 : rdptr_q + 1'b1;
    rdptrm1_d = rdinc ? rdptr_q : rdptrm1_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      wrptr_q   <= '0;
      rdptr_q   <= '0;
      rdptrm1_q <= LAST;
    end else begin
      wrptr_q   <= wrptr_d;
      rdptr_q   <= rdptr_d;
      rdptrm1_q <= rdptrm1_d;
    end
  end
  powlib_dpram #(.W(W), .D(D), .EDBG(EDBG), .ID({ID, "_DPRAM"})) u_ram (
    .clk    (clk),
    .wridx  (wrptr_q),
    .wrdata (f.wrdata),
    .wrvld  (wrinc),
    .rdidx  (rdptr_q),
    .rddata (f.rddata)
  );
endmodule

// File: tb/tb_powlib_sfifo_core.sv
// tb_powlib_sfifo_core: directed scoreboard bench for D=8 and D=5 FIFO instances.
module tb_powlib_sfifo_core;
  logic clk = 0;
  logic rst = 0;
  int checks = 0;
  int errors = 0;
  int sel = 0;
  int cap = 7;
  logic [15:0] q[$];
  always #5 clk = ~clk;
  powlib_sfifo_core_if #(.W(16)) fa ();
  powlib_sfifo_core_if #(.W(16)) fb ();
  powlib_sfifo_core #(.W(16), .D(8)) ua (.clk(clk), .rst(rst), .f(fa.slave));
  powlib_sfifo_core #(.W(16), .D(5)) ub (.clk(clk), .rst(rst), .f(fb.slave));

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic wv, input logic [15:0] wd, input logic rr, input string tag);
    logic wr_o, rv_o, rd_acc, wr_acc;
    logic [15:0] rdat;
    fa.wrvld = (sel == 0) ? wv : 1'b0;
    fa.rdrdy = (sel == 0) ? rr : 1'b0;
    fa.wrdata = wd;
    fb.wrvld = (sel == 1) ? wv : 1'b0;
    fb.rdrdy = (sel == 1) ? rr : 1'b0;
    fb.wrdata = wd;
    @(negedge clk);
    wr_o = (sel == 1) ? fb.wrrdy : fa.wrrdy;
    rv_o = (sel == 1) ? fb.rdvld : fa.rdvld;
    rdat = (sel == 1) ? fb.rddata : fa.rddata;
    chk({31'd0, wr_o}, {31'd0, q.size() < cap}, {tag, "_wrrdy"});
    chk({31'd0, rv_o}, {31'd0, q.size() != 0}, {tag, "_rdvld"});
    rd_acc = rr && q.size() != 0;
    wr_acc = wv && q.size() < cap;
    if (rd_acc) chk({16'd0, rdat}, {16'd0, q[0]}, {tag, "_data"});
    @(posedge clk);
    #1;
    if (rd_acc) void'(q.pop_front());
    if (wr_acc) q.push_back(wd);
  endtask

  task automatic do_reset();
    fa.wrvld = 0; fa.rdrdy = 0; fb.wrvld = 0; fb.rdrdy = 0;
    rst = 0;
    @(posedge clk);
    #1;
    rst = 1;
    q.delete();
    chk({29'd0, ua.wrptr_q}, 0, "rst_wrptr8");
    chk({29'd0, ua.rdptr_q}, 0, "rst_rdptr8");
    chk({29'd0, ua.rdptrm1_q}, 7, "rst_rdptrm1_8");
    chk({29'd0, ub.rdptrm1_q}, 4, "rst_rdptrm1_5");
  endtask

  initial begin
    fa.wrdata = 0; fb.wrdata = 0;
    do_reset();
    sel = 0; cap = 7;
    step(0, 0, 0, "idle");
    for (int i = 1; i <= 7; i++) step(1, 16'(i), 0, "fill");
    step(1, 16'h0008, 0, "full");
    for (int i = 0; i < 7; i++) step(0, 0, 1, "drain");
    step(0, 0, 0, "empty");
    step(1, 16'hA5A5, 0, "lat_w");
    step(0, 0, 1, "lat_r");
    step(0, 0, 0, "lat_empty");
    step(1, 16'h0100, 0, "pre");
    step(1, 16'h0101, 0, "pre");
    for (int i = 2; i < 42; i++) step(1, 16'h0100 + 16'(i), 1, "stream");
    for (int i = 0; i < 3; i++) step(0, 0, 1, "sdrain");
    step(0, 0, 0, "sempty");
    sel = 1; cap = 4;
    for (int i = 0; i < 5; i++) step(1, 16'h0050 + 16'(i), 0, "f5");
    chk({29'd0, ub.wrptr_q}, 4, "d5_wrptr_full");
    chk(q.size(), 4, "d5_accepted");
    for (int i = 0; i < 4; i++) step(0, 0, 1, "d5");
    chk({29'd0, ub.rdptr_q}, 4, "d5_rdptr_end");
    step(1, 16'h0077, 0, "d5_wrap_w");
    step(0, 0, 1, "d5_wrap_r");
    chk({29'd0, ub.wrptr_q}, 0, "d5_wrptr_wrap");
    chk({29'd0, ub.rdptr_q}, 0, "d5_rdptr_wrap");
    chk({29'd0, ub.rdptrm1_q}, 4, "d5_rdptrm1");
    sel = 0; cap = 7;
    for (int i = 0; i < 3; i++) step(1, 16'h0E00 + 16'(i), 0, "mid");
    do_reset();
    step(0, 0, 0, "rst_idle");
    step(1, 16'h1234, 0, "rst_w");
    step(0, 0, 1, "rst_r");
    step(0, 0, 0, "rst_empty");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
